// File: rtl/axis_axil_master.sv
// AXI-Stream to AXI-Lite master bridge: each input stream word becomes a write to AXI_ADDR,
// and reads from AXI_ADDR (gated by rd_en) refill the output stream. Error responses are counted.
module axis_axil_master #(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR       = 32'h0000_0001
) (
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic [AXI_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,

  output logic [AXI_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,

  output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axil_araddr,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready,

  input  logic                          rd_en,
  output logic [15:0]                   wr_err_cnt,
  output logic [15:0]                   rd_err_cnt
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_OUT} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic                      aw_done_reg, w_done_reg;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_reg, araddr_reg;
  logic [AXI_DATA_WIDTH-1:0] wdata_reg, tdata_reg;
  logic [15:0]               wr_err_cnt_reg, rd_err_cnt_reg;
  logic                      wr_err_inc, rd_err_inc;

  generate
    for (genvar gi = 0; gi < AXI_DATA_WIDTH/8; gi++) begin : g_wstrb
      assign m_axil_wstrb[gi] = 1'b1;
    end
  endgenerate

  // ---------------- write path ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state_reg <= W_IDLE;
    else          w_state_reg <= w_state_next;
  end

  // W_ADDR is left only once both done flags are registered, so each valid
  // has already dropped for a cycle before bready rises.
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (s_axis_tvalid)              w_state_next = W_ADDR;
      W_ADDR:  if (aw_done_reg && w_done_reg)  w_state_next = W_RESP;
      W_RESP:  if (m_axil_bvalid)              w_state_next = W_IDLE;
      default:                                 w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready  = (w_state_reg == W_IDLE);
    m_axil_awvalid = (w_state_reg == W_ADDR) && !aw_done_reg;
    m_axil_wvalid  = (w_state_reg == W_ADDR) && !w_done_reg;
    m_axil_bready  = (w_state_reg == W_RESP);
    wr_err_inc     = (w_state_reg == W_RESP) && m_axil_bvalid && (m_axil_bresp != 2'b00);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
    end else begin
      if (w_state_reg == W_IDLE) begin
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
        if (s_axis_tvalid) begin
          awaddr_reg <= AXI_ADDR;
          wdata_reg  <= s_axis_tdata;
        end
      end else if (w_state_reg == W_ADDR) begin
        if (m_axil_awvalid && m_axil_awready) aw_done_reg <= 1'b1;
        if (m_axil_wvalid && m_axil_wready)   w_done_reg  <= 1'b1;
      end
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state_reg <= R_IDLE;
    else          r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (rd_en)          r_state_next = R_ADDR;
      R_ADDR:  if (m_axil_arready) r_state_next = R_DATA;
      R_DATA:  if (m_axil_rvalid)  r_state_next = (m_axil_rresp == 2'b00) ? R_OUT : R_IDLE;
      R_OUT:   if (m_axis_tready)  r_state_next = R_IDLE;
      default:                     r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    m_axil_arvalid = (r_state_reg == R_ADDR);
    m_axil_rready  = (r_state_reg == R_DATA);
    m_axis_tvalid  = (r_state_reg == R_OUT);
    rd_err_inc     = (r_state_reg == R_DATA) && m_axil_rvalid && (m_axil_rresp != 2'b00);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      araddr_reg <= '0;
      tdata_reg  <= '0;
    end else begin
      if (r_state_reg == R_IDLE && rd_en)
        araddr_reg <= AXI_ADDR;
      if (r_state_reg == R_DATA && m_axil_rvalid && m_axil_rresp == 2'b00)
        tdata_reg <= m_axil_rdata;
      else if (r_state_reg == R_OUT && m_axis_tready)
        tdata_reg <= '0;
    end
  end

  // ---------------- saturating error counters ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                   wr_err_cnt_reg <= 16'd0;
    else if (wr_err_inc && wr_err_cnt_reg != 16'hFFFF) wr_err_cnt_reg <= wr_err_cnt_reg + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                   rd_err_cnt_reg <= 16'd0;
    else if (rd_err_inc && rd_err_cnt_reg != 16'hFFFF) rd_err_cnt_reg <= rd_err_cnt_reg + 16'd1;
  end

  assign m_axil_awaddr = awaddr_reg;
  assign m_axil_wdata  = wdata_reg;
  assign m_axil_araddr = araddr_reg;
  assign m_axis_tdata  = tdata_reg;
  assign wr_err_cnt    = wr_err_cnt_reg;
  assign rd_err_cnt    = rd_err_cnt_reg;

endmodule

// File: tb/tb_axis_axil_master.sv
// Directed bench for axis_axil_master: table-driven write and read transactions against a
// cycle-stepped AXI-Lite slave model, plus hand sequences for saturation and async reset.
module tb_axis_axil_master;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axil_awaddr;
  logic        m_axil_awvalid;
  logic        m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;
  logic        rd_en;
  logic [15:0] wr_err_cnt;
  logic [15:0] rd_err_cnt;

  axis_axil_master #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .AXI_ADDR      (32'h0000_0001)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axil_awaddr (m_axil_awaddr),
    .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata  (m_axil_wdata),
    .m_axil_wstrb  (m_axil_wstrb),
    .m_axil_wvalid (m_axil_wvalid),
    .m_axil_wready (m_axil_wready),
    .m_axil_bresp  (m_axil_bresp),
    .m_axil_bvalid (m_axil_bvalid),
    .m_axil_bready (m_axil_bready),
    .m_axil_araddr (m_axil_araddr),
    .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata  (m_axil_rdata),
    .m_axil_rresp  (m_axil_rresp),
    .m_axil_rvalid (m_axil_rvalid),
    .m_axil_rready (m_axil_rready),
    .rd_en         (rd_en),
    .wr_err_cnt    (wr_err_cnt),
    .rd_err_cnt    (rd_err_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // aw_lat/w_lat: ready is held low for that many cycles after the write starts.
  typedef struct {
    logic [31:0] tdata;
    int          aw_lat;
    int          w_lat;
    logic [1:0]  bresp;
    logic [15:0] exp_err;
    int          exp_cyc;
  } wr_vec_t;

  // ar_lat: arready held low that many cycles; tr_lat: tready held low that many tvalid cycles.
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_lat;
    int          tr_lat;
    logic [15:0] exp_err;
  } rd_vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_write(input wr_vec_t v);
    int cyc, aw_cnt, w_cnt, b_cnt;
    bit aw_pend, w_pend, b_pend, aw_done, w_done, b_done;
    cyc = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_pend = 0; w_pend = 0; b_pend = 0; aw_done = 0; w_done = 0; b_done = 0;
    @(negedge aclk);
    chk("wr_tready_idle", 32'(s_axis_tready), 32'd1);
    s_axis_tdata  = v.tdata;
    s_axis_tvalid = 1'b1;
    while (!b_done && cyc < 40) begin
      @(negedge aclk);
      cyc++;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      if (aw_pend) aw_done = 1;
      if (w_pend)  w_done  = 1;
      if (b_pend) begin
        b_done        = 1;
        m_axil_bvalid = 1'b0;
        m_axil_bresp  = 2'b00;
      end
      aw_pend = 0; w_pend = 0; b_pend = 0;
      if (!b_done) begin
        if (m_axil_awvalid) chk("wr_awaddr", m_axil_awaddr, 32'h0000_0001);
        if (m_axil_wvalid) begin
          chk("wr_wdata", m_axil_wdata, v.tdata);
          chk("wr_wstrb", 32'(m_axil_wstrb), 32'hF);
        end
        m_axil_awready = (cyc > v.aw_lat);
        m_axil_wready  = (cyc > v.w_lat);
        if (m_axil_awvalid && m_axil_awready) begin aw_pend = 1; aw_cnt++; end
        if (m_axil_wvalid && m_axil_wready)   begin w_pend  = 1; w_cnt++;  end
        if (aw_done && w_done) begin
          m_axil_bvalid = 1'b1;
          m_axil_bresp  = v.bresp;
        end
        if (m_axil_bvalid && m_axil_bready) begin b_pend = 1; b_cnt++; end
      end
    end
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    chk("wr_completed",   32'(b_done), 32'd1);
    chk("wr_aw_count",    aw_cnt, 32'd1);
    chk("wr_w_count",     w_cnt,  32'd1);
    chk("wr_b_count",     b_cnt,  32'd1);
    chk("wr_tready_back", 32'(s_axis_tready),  32'd1);
    chk("wr_no_retry_aw", 32'(m_axil_awvalid), 32'd0);
    chk("wr_loop_cycles", cyc, v.exp_cyc);
    chk("wr_err_cnt",     32'(wr_err_cnt), 32'(v.exp_err));
    $display("wr tdata=%h aw_lat=%0d w_lat=%0d bresp=%b cycles=%0d wr_err_cnt=%0d",
             v.tdata, v.aw_lat, v.w_lat, v.bresp, cyc, wr_err_cnt);
  endtask

  task automatic do_read(input rd_vec_t v);
    int cyc, ar_cnt, r_cnt, tv_cnt, first_tv;
    bit ar_pend, r_pend, t_pend, ar_done, r_done, fin;
    cyc = 0; ar_cnt = 0; r_cnt = 0; tv_cnt = 0; first_tv = 0;
    ar_pend = 0; r_pend = 0; t_pend = 0; ar_done = 0; r_done = 0; fin = 0;
    @(negedge aclk);
    rd_en = 1'b1;
    while (!fin && cyc < 60) begin
      @(negedge aclk);
      cyc++;
      if (ar_pend) ar_done = 1;
      if (r_pend) begin
        r_done        = 1;
        m_axil_rvalid = 1'b0;
        m_axil_rdata  = '0;
        m_axil_rresp  = 2'b00;
        if (v.rresp != 2'b00) fin = 1;
      end
      if (t_pend) begin
        fin           = 1;
        m_axis_tready = 1'b0;
      end
      ar_pend = 0; r_pend = 0; t_pend = 0;
      if (!fin) begin
        if (m_axil_arvalid) chk("rd_araddr", m_axil_araddr, 32'h0000_0001);
        m_axil_arready = (cyc > v.ar_lat);
        if (m_axil_arvalid && m_axil_arready) begin ar_pend = 1; ar_cnt++; end
        if (ar_done && !r_done) begin
          m_axil_rvalid = 1'b1;
          m_axil_rdata  = v.rdata;
          m_axil_rresp  = v.rresp;
        end
        if (m_axil_rvalid && m_axil_rready) begin r_pend = 1; r_cnt++; end
        if (m_axis_tvalid) begin
          tv_cnt++;
          if (first_tv == 0) first_tv = cyc;
          chk("rd_tdata_stable", m_axis_tdata, v.rdata);
          m_axis_tready = (tv_cnt > v.tr_lat);
          if (m_axis_tready) t_pend = 1;
        end
      end
    end
    rd_en          = 1'b0;
    m_axil_arready = 1'b0;
    chk("rd_completed",     32'(fin), 32'd1);
    chk("rd_ar_count",      ar_cnt, 32'd1);
    chk("rd_r_count",       r_cnt,  32'd1);
    chk("rd_tvalid_cycles", tv_cnt, (v.rresp == 2'b00) ? v.tr_lat + 1 : 0);
    if (v.rresp == 2'b00) chk("rd_tvalid_latency", first_tv, v.ar_lat + 3);
    chk("rd_tvalid_clear",  32'(m_axis_tvalid), 32'd0);
    chk("rd_tdata_clear",   m_axis_tdata, 32'd0);
    chk("rd_err_cnt",       32'(rd_err_cnt), 32'(v.exp_err));
    $display("rd rdata=%h rresp=%b ar_lat=%0d tr_lat=%0d tvalid_cycles=%0d rd_err_cnt=%0d",
             v.rdata, v.rresp, v.ar_lat, v.tr_lat, tv_cnt, rd_err_cnt);
  endtask

  wr_vec_t wr_tbl [6];
  rd_vec_t rd_tbl [6];
  wr_vec_t wv;
  rd_vec_t rv;

  initial begin
    // Loop cycles = max(aw_lat, w_lat) + 4 (zero-wait slave gives 4).
    wr_tbl[0] = '{32'hDEAD_BEEF, 0, 0, 2'b00, 16'd0, 4};
    wr_tbl[1] = '{32'h0000_00A5, 4, 1, 2'b00, 16'd0, 8};
    wr_tbl[2] = '{32'h5A5A_C3C3, 1, 4, 2'b00, 16'd0, 8};
    wr_tbl[3] = '{32'h0000_0011, 0, 0, 2'b11, 16'd1, 4};
    wr_tbl[4] = '{32'h0000_0022, 0, 0, 2'b11, 16'd2, 4};
    wr_tbl[5] = '{32'h0000_0033, 0, 0, 2'b11, 16'd3, 4};

    rd_tbl[0] = '{32'h1234_5678, 2'b00, 1, 5, 16'd0};
    rd_tbl[1] = '{32'hA5A5_0F0F, 2'b00, 0, 0, 16'd0};
    rd_tbl[2] = '{32'hCAFE_F00D, 2'b00, 7, 2, 16'd0};
    rd_tbl[3] = '{32'h1111_1111, 2'b11, 1, 0, 16'd1};
    rd_tbl[4] = '{32'h2222_2222, 2'b11, 0, 0, 16'd2};
    rd_tbl[5] = '{32'h3333_3333, 2'b10, 2, 0, 16'd3};

    aresetn        = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    m_axis_tready  = 1'b0;
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bresp   = 2'b00;
    m_axil_bvalid  = 1'b0;
    m_axil_arready = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = 2'b00;
    m_axil_rvalid  = 1'b0;
    rd_en          = 1'b0;

    repeat (3) @(negedge aclk);
    chk("rst_tready",  32'(s_axis_tready),  32'd1);
    chk("rst_awvalid", 32'(m_axil_awvalid), 32'd0);
    chk("rst_wvalid",  32'(m_axil_wvalid),  32'd0);
    chk("rst_bready",  32'(m_axil_bready),  32'd0);
    chk("rst_arvalid", 32'(m_axil_arvalid), 32'd0);
    chk("rst_rready",  32'(m_axil_rready),  32'd0);
    chk("rst_tvalid",  32'(m_axis_tvalid),  32'd0);
    chk("rst_awaddr",  m_axil_awaddr, 32'd0);
    chk("rst_wdata",   m_axil_wdata,  32'd0);
    chk("rst_araddr",  m_axil_araddr, 32'd0);
    chk("rst_tdata",   m_axis_tdata,  32'd0);
    chk("rst_wr_err",  32'(wr_err_cnt), 32'd0);
    chk("rst_rd_err",  32'(rd_err_cnt), 32'd0);
    aresetn = 1'b1;

    for (int i = 0; i < 6; i++) do_write(wr_tbl[i]);
    for (int i = 0; i < 6; i++) do_read(rd_tbl[i]);

    // Saturation: preload the read error counter just below the limit.
    @(negedge aclk);
    force dut.rd_err_cnt_reg = 16'hFFFD;
    @(negedge aclk);
    release dut.rd_err_cnt_reg;
    rv = '{32'h4444_4444, 2'b11, 0, 0, 16'hFFFE};
    do_read(rv);
    rv = '{32'h5555_5555, 2'b11, 0, 0, 16'hFFFF};
    do_read(rv);
    rv = '{32'h6666_6666, 2'b11, 1, 0, 16'hFFFF};
    do_read(rv);
    chk("wr_err_unaffected", 32'(wr_err_cnt), 32'd3);

    // Async reset with a read word waiting on m_axis and a write stuck in W_ADDR.
    @(negedge aclk);
    rd_en          = 1'b1;
    m_axil_arready = 1'b1;
    for (int i = 0; i < 10 && !m_axis_tvalid; i++) begin
      @(negedge aclk);
      m_axil_rvalid = m_axil_rready;
      m_axil_rdata  = 32'h5A5A_5A5A;
      m_axil_rresp  = 2'b00;
    end
    rd_en          = 1'b0;
    m_axil_arready = 1'b0;
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    s_axis_tdata  = 32'h0000_0077;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("pre_rst_awvalid", 32'(m_axil_awvalid), 32'd1);
    chk("pre_rst_wvalid",  32'(m_axil_wvalid),  32'd1);
    chk("pre_rst_tvalid2", 32'(m_axis_tvalid),  32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_awvalid", 32'(m_axil_awvalid), 32'd0);
    chk("arst_wvalid",  32'(m_axil_wvalid),  32'd0);
    chk("arst_tvalid",  32'(m_axis_tvalid),  32'd0);
    chk("arst_tdata",   m_axis_tdata,        32'd0);
    chk("arst_awaddr",  m_axil_awaddr,       32'd0);
    chk("arst_tready",  32'(s_axis_tready),  32'd1);
    chk("arst_wr_err",  32'(wr_err_cnt),     32'd0);
    chk("arst_rd_err",  32'(rd_err_cnt),     32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_tready",  32'(s_axis_tready),  32'd1);
    chk("post_rst_awvalid", 32'(m_axil_awvalid), 32'd0);
    chk("post_rst_arvalid", 32'(m_axil_arvalid), 32'd0);
    wv = '{32'h0BAD_F00D, 0, 0, 2'b00, 16'd0, 4};
    do_write(wv);
    rv = '{32'h8765_4321, 2'b00, 1, 1, 16'd0};
    do_read(rv);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
